// File: rtl/hazard_unit_mc_if.sv
// Hazard-control bundle between the 5-stage datapath and hazard_unit_mc.
//   master : datapath side. Drives the hazard-detection inputs and receives
//            the forwarding selects and the stall/flush enables.
//   slave  : hazard unit side.
// Optional: with HAZARD_PERF_EN defined, StallCycles/FlushCycles (PERF_W
// bits each) are added to the bundle.
interface hazard_unit_mc_if #(
  parameter int NSRC = 3
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W = 32
`endif
);
  logic [NSRC-1:0]   Match_E_M;
  logic [NSRC-1:0]   Match_E_W;
  logic [NSRC-1:0]   Match_D_E;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              MemtoRegE;
  logic              BranchTakenE;
  logic              PCWrPendingF;
  logic              PCSrcW;
  logic              MulStartE;
  logic              MemReqM;
  logic              MemReadyM;
  logic [2*NSRC-1:0] ForwardE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushM, FlushW;
  logic              MulBusy;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] StallCycles;
  logic [PERF_W-1:0] FlushCycles;
`endif

  modport master (
    output Match_E_M, Match_E_W, Match_D_E, RegWriteM, RegWriteW, MemtoRegE,
           BranchTakenE, PCWrPendingF, PCSrcW, MulStartE, MemReqM, MemReadyM,
    input  ForwardE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, MulBusy
`ifdef HAZARD_PERF_EN
           , StallCycles, FlushCycles
`endif
  );

  modport slave (
    input  Match_E_M, Match_E_W, Match_D_E, RegWriteM, RegWriteW, MemtoRegE,
           BranchTakenE, PCWrPendingF, PCSrcW, MulStartE, MemReqM, MemReadyM,
    output ForwardE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, MulBusy
`ifdef HAZARD_PERF_EN
           , StallCycles, FlushCycles
`endif
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc : hazard controller for the 5-stage (F/D/E/M/W) core.
//   Forwarding for NSRC execute operands, load-use / branch / PC-write
//   hazards, multi-cycle multiply occupancy of E and variable-latency data
//   memory stalls. All outputs are combinational from the inputs and the
//   4-bit multiply cycle counter.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   hz    : hazard_unit_mc_if.slave (detection inputs, forward selects,
//           stall/flush enables, MulBusy)
// Optional feature macro: HAZARD_PERF_EN adds saturating StallCycles /
// FlushCycles counters to the bundle.

// One forwarding mux select per execute operand; M is the younger result,
// so it wins when both later stages match.
module hazard_fwd_lane (
  input  logic       matchM,
  input  logic       matchW,
  input  logic       regWriteM,
  input  logic       regWriteW,
  output logic [1:0] fwd
);
  assign fwd = (matchM & regWriteM) ? 2'b10 :
               (matchW & regWriteW) ? 2'b01 : 2'b00;
endmodule

module hazard_unit_mc #(
  parameter int NSRC    = 3,
  parameter int MUL_LAT = 3
`ifdef HAZARD_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input logic              clk,
  input logic              reset,
  hazard_unit_mc_if.slave  hz
);
  localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

  logic [3:0]            mulCnt;
  logic [NSRC-1:0][1:0]  laneFwd;
  logic                  memStall, mulBusy, ldrStall;
  logic                  stallF, stallD, stallE, stallM;
  logic                  flushD, flushE, flushM, flushW;

  for (genvar i = 0; i < NSRC; i++) begin : gLane
    hazard_fwd_lane uLane (
      .matchM    (hz.Match_E_M[i]),
      .matchW    (hz.Match_E_W[i]),
      .regWriteM (hz.RegWriteM),
      .regWriteW (hz.RegWriteW),
      .fwd       (laneFwd[i])
    );
  end

  assign memStall = hz.MemReqM & ~hz.MemReadyM;
  // The final multiply cycle is not busy: the instruction advances.
  assign mulBusy  = ~memStall & hz.MulStartE & (mulCnt != MUL_LAST);
  assign ldrStall = (|hz.Match_D_E) & hz.MemtoRegE;

  always_comb begin
    stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
    flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
    if (reset) begin
      flushD = 1'b1; flushE = 1'b1; flushM = 1'b1; flushW = 1'b1;
    end else if (memStall) begin
      // Whole pipe frozen behind M; only W drains as a bubble.
      stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1;
      flushW = 1'b1;
    end else begin
      stallF = mulBusy | ldrStall | hz.PCWrPendingF;
      stallD = mulBusy | ldrStall;
      stallE = mulBusy;
      flushM = mulBusy;
      flushE = ldrStall | hz.BranchTakenE;
      // A held D instruction must never be killed.
      flushD = (hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE) & ~stallD;
    end
  end

  assign hz.ForwardE = reset ? '0 : laneFwd;
  assign hz.StallF   = stallF;
  assign hz.StallD   = stallD;
  assign hz.StallE   = stallE;
  assign hz.StallM   = stallM;
  assign hz.FlushD   = flushD;
  assign hz.FlushE   = flushE;
  assign hz.FlushM   = flushM;
  assign hz.FlushW   = flushW;
  assign hz.MulBusy  = reset ? 1'b0 : mulBusy;

  // Cycles the current multiply has spent in E; frozen by memory stalls.
  always_ff @(posedge clk) begin
    if (reset)                mulCnt <= '0;
    else if (memStall)        mulCnt <= mulCnt;
    else if (mulBusy)         mulCnt <= mulCnt + 4'd1;
    else                      mulCnt <= '0;
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stallCyc, flushCyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCyc <= '0;
      flushCyc <= '0;
    end else begin
      if (stallF && !(&stallCyc))            stallCyc <= stallCyc + 1'b1;
      if ((flushE | flushD) && !(&flushCyc)) flushCyc <= flushCyc + 1'b1;
    end
  end

  assign hz.StallCycles = stallCyc;
  assign hz.FlushCycles = flushCyc;
`endif
endmodule

// File: tb/tb_hazard_unit_mc.sv
module tb_hazard_unit_mc;
  localparam int NSRC    = 3;
  localparam int MUL_LAT = 3;

  typedef struct packed {
    logic       rst;
    logic [2:0] mEM, mEW, mDE;
    logic       rwM, rwW, m2r, br, pcw, pcs, mul, req, rdy;
  } stim_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] fwd;
    logic [3:0] stall;  // {F,D,E,M}
    logic [3:0] flush;  // {D,E,M,W}
    logic       busy;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_unit_mc_if #(.NSRC(NSRC)) hz ();
  hazard_unit_mc #(.NSRC(NSRC), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .hz(hz)
  );

  resp_t q[$];
  int    tests = 0;
  int    fails = 0;
  int    mulDone = 0;  // cycles the multiply in E has already progressed

  // Reference: view each hazard as "hold every stage up to the deepest
  // blocked one, and drop a bubble into the stage right behind it".
  function automatic resp_t model(stim_t s, int done);
    resp_t r;
    logic  mem, busy, ldr;
    int    deepest;  // 0 none, 1 F, 2 D, 3 E, 4 M
    r = '0;
    r.rst = s.rst;
    if (s.rst) begin
      r.flush = 4'b1111;
      return r;
    end
    for (int i = 0; i < NSRC; i++)
      r.fwd[2*i +: 2] = (s.mEM[i] && s.rwM) ? 2'd2 : (s.mEW[i] && s.rwW) ? 2'd1 : 2'd0;
    mem  = s.req && !s.rdy;
    busy = !mem && s.mul && (done + 1 < MUL_LAT);
    ldr  = (s.mDE != 0) && s.m2r;
    deepest = mem ? 4 : busy ? 3 : ldr ? 2 : s.pcw ? 1 : 0;
    r.stall = {deepest >= 1, deepest >= 2, deepest >= 3, deepest >= 4};
    r.flush[2] = (deepest == 2) || (!mem && s.br);
    r.flush[1] = (deepest == 3);
    r.flush[0] = (deepest == 4);
    r.flush[3] = (deepest < 2) && (s.pcw || s.pcs || s.br);
    r.busy = busy;
    return r;
  endfunction

  function automatic int nextDone(stim_t s, int done);
    logic mem;
    mem = s.req && !s.rdy;
    if (s.rst) return 0;
    if (mem)   return done;
    if (s.mul && (done + 1 < MUL_LAT)) return done + 1;
    return 0;
  endfunction

  task automatic drive(stim_t s);
    @(posedge clk);
    #1;
    reset           = s.rst;
    hz.Match_E_M    = s.mEM;
    hz.Match_E_W    = s.mEW;
    hz.Match_D_E    = s.mDE;
    hz.RegWriteM    = s.rwM;
    hz.RegWriteW    = s.rwW;
    hz.MemtoRegE    = s.m2r;
    hz.BranchTakenE = s.br;
    hz.PCWrPendingF = s.pcw;
    hz.PCSrcW       = s.pcs;
    hz.MulStartE    = s.mul;
    hz.MemReqM      = s.req;
    hz.MemReadyM    = s.rdy;
    q.push_back(model(s, mulDone));
    mulDone = nextDone(s, mulDone);
  endtask

  task automatic chk(string name, logic [5:0] act, logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%b exp=%b at %0t", name, act, exp, $time);
    end
  endtask

`ifdef HAZARD_PERF_EN
  longint expStallCyc = 0, expFlushCyc = 0;
`endif

  // Monitor: outputs are valid every cycle once stimulus has been applied.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      resp_t e;
      e = q.pop_front();
      chk("ForwardE", hz.ForwardE, e.fwd);
      chk("Stall_FDEM", {2'b0, hz.StallF, hz.StallD, hz.StallE, hz.StallM}, {2'b0, e.stall});
      chk("Flush_DEMW", {2'b0, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW}, {2'b0, e.flush});
      chk("MulBusy", {5'b0, hz.MulBusy}, {5'b0, e.busy});
`ifdef HAZARD_PERF_EN
      if (!e.rst) begin
        chk("StallCycles_lo", hz.StallCycles[5:0], expStallCyc[5:0]);
        chk("FlushCycles_lo", hz.FlushCycles[5:0], expFlushCyc[5:0]);
      end
      if (e.rst) begin
        expStallCyc = 0; expFlushCyc = 0;
      end else begin
        if (e.stall[3]) expStallCyc++;
        if (e.flush[3] || e.flush[2]) expFlushCyc++;
      end
`endif
    end
  end

  initial begin
    stim_t s;
    stim_t idle;
    idle = '0;
    hz.Match_E_M = '0; hz.Match_E_W = '0; hz.Match_D_E = '0;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.MemtoRegE = 0; hz.BranchTakenE = 0;
    hz.PCWrPendingF = 0; hz.PCSrcW = 0; hz.MulStartE = 0; hz.MemReqM = 0; hz.MemReadyM = 0;

    // Reset state, with hazard inputs active to show they are masked.
    s = idle; s.rst = 1; s.mEM = 3'b111; s.rwM = 1; s.mul = 1; s.pcw = 1;
    repeat (3) drive(s);

    // Forwarding: M wins over W on operand 0.
    s = idle; s.mEM = 3'b001; s.mEW = 3'b011; s.rwM = 1; s.rwW = 1;
    drive(s);
    s.rwM = 0; drive(s);

    // Multiply held for MUL_LAT cycles.
    s = idle; s.mul = 1;
    repeat (MUL_LAT) drive(s);
    drive(idle);

    // Memory stall in the middle of a multiply freezes its progress.
    s = idle; s.mul = 1; drive(s);
    s.req = 1; s.rdy = 0; repeat (4) drive(s);
    s.rdy = 1; drive(s);
    s.req = 0; drive(s);
    drive(idle);

    // Load-use together with a pending PC write: D held, so no FlushD.
    s = idle; s.m2r = 1; s.mDE = 3'b010; s.pcw = 1; drive(s);

    // Taken branch without stalls.
    s = idle; s.br = 1; drive(s);
    s = idle; s.pcs = 1; drive(s);

    // Reset mid-multiply abandons it; a new multiply starts from scratch.
    s = idle; s.mul = 1; drive(s);
    s.rst = 1; drive(s);
    s.rst = 0; repeat (MUL_LAT) drive(s);
    drive(idle);

    // Randomized traffic honouring the decoder's exclusivity guarantee.
    for (int n = 0; n < 2000; n++) begin
      s.rst = ($urandom_range(0, 99) < 2);
      s.mEM = 3'($urandom); s.mEW = 3'($urandom); s.mDE = 3'($urandom);
      s.rwM = 1'($urandom); s.rwW = 1'($urandom);
      s.pcw = ($urandom_range(0, 9) == 0);
      s.pcs = ($urandom_range(0, 9) == 0);
      s.req = ($urandom_range(0, 9) < 3);
      s.rdy = 1'($urandom);
      s.mul = (mulDone > 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 5) == 0);
      if (s.mul) begin
        s.m2r = 0; s.br = 0;
      end else begin
        s.m2r = ($urandom_range(0, 3) == 0);
        s.br  = ($urandom_range(0, 7) == 0);
      end
      drive(s);
    end

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain act=%0d pending exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
